// File: rtl/clocked_cnt161.sv
// 74161/74163-style presettable binary counter, clocked entirely on CLK_DRV.
// The slow logic-level CLK is edge-detected against its registered sample.
`timescale 1ns/1ps
module clocked_cnt161 #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SYNC_CLR = 1'b0
) (
  input  logic             CLK_DRV,
  input  logic             RST_N,
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_COUNT
  } action_t;

  logic [WIDTH-1:0] cnt;
  logic             clk_q;
  logic             rise;
  logic             async_clr;
  action_t          action;

  assign rise      = CLK & ~clk_q;
  assign async_clr = ~SYNC_CLR & ~CLR_N;

  // Async clear overrides everything; all other actions need a CLK rising edge.
  always_comb begin
    action = ACT_HOLD;
    if (async_clr) begin
      action = ACT_CLEAR;
    end else if (!rise) begin
      action = ACT_HOLD;
    end else if (!CLR_N) begin
      action = ACT_CLEAR;
    end else if (!LOAD_N) begin
      action = ACT_LOAD;
    end else if (ENP && ENT) begin
      action = ACT_COUNT;
    end
  end

  // clk_q resets high so a CLK already high at reset release is not an edge.
  always_ff @(posedge CLK_DRV or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= '0;
      clk_q <= 1'b1;
    end else begin
      clk_q <= CLK;
      case (action)
        ACT_CLEAR: cnt <= '0;
        ACT_LOAD:  cnt <= D;
        ACT_COUNT: cnt <= cnt + WIDTH'(1);
        default:   cnt <= cnt;
      endcase
    end
  end

  assign Q   = async_clr ? '0 : cnt;
  assign RCO = ENT & (&Q);

endmodule

// File: doc/clocked_cnt161.md
# clocked_cnt161

Synchronous emulation of a 74161/74163-style presettable binary counter. It is driven by the fast design clock and advances on rising edges of a slower logic-level clock input. It sits directly upstream of the clocked SR flip-flops in the discrete-logic recreations. Its count bits and ripple-carry output drive those flip-flops' S/R and clock inputs, for example in score, timer and motion chains. Everything is evaluated on `CLK_DRV`, so the rest of the design sees clean, glitch-free, single-clock behaviour.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits; must be ≥ 1.
- `SYNC_CLR`, default 0: 0 gives 74161 behaviour (asynchronous clear); 1 gives 74163 behaviour (clear takes effect on the counting edge).

Ports:
- `CLK_DRV`  in  1: fast design clock. All state changes on its rising edge. Must be at least 2× faster than `CLK` toggling.
- `RST_N`  in  1: asynchronous, active-low reset.
- `CLK`  in  1: logic-level counter clock. The counter acts on its rising edge, as sampled by `CLK_DRV`.
- `CLR_N`  in  1: active-low clear; behaviour depends on `SYNC_CLR`.
- `LOAD_N`  in  1: active-low parallel load, synchronous to a `CLK` rising edge.
- `ENP`  in  1: count enable P.
- `ENT`  in  1: count enable T; also gates `RCO`.
- `D`  in  WIDTH: parallel load data.
- `Q`  out  WIDTH: counter value.
- `RCO`  out  1: ripple carry out.

## Operation
Internal state:
- `CNT[WIDTH-1:0]`: the count register.
- `CLK_Q`: `CLK` as sampled at the previous `CLK_DRV` edge.

Edge detection:
- `RISE = CLK & ~CLK_Q`, evaluated combinationally from the live `CLK` and the registered `CLK_Q`.
- `CLK_Q <= CLK` on every `CLK_DRV` edge.

Action at each `CLK_DRV` rising edge, highest priority first:
1. `SYNC_CLR=0` and `CLR_N=0`: `CNT <= 0`, whether or not `RISE` is asserted.
2. `RISE=0`: `CNT` holds.
3. `SYNC_CLR=1` and `CLR_N=0`: `CNT <= 0`.
4. `LOAD_N=0`: `CNT <= D`. Enables are ignored.
5. `ENP=1` and `ENT=1`: `CNT <= CNT + 1` modulo 2^WIDTH, so all-ones wraps to 0.
6. Otherwise: `CNT` holds.

Outputs:
- `Q`:
  - With `SYNC_CLR=0`, `Q = CLR_N ? CNT : 0`, combinational. The async clear is therefore visible immediately, without waiting for a `CLK_DRV` edge.
  - With `SYNC_CLR=1`, `Q = CNT`.
- `RCO = ENT & (Q == all ones)`, combinational. It is independent of `ENP`, `LOAD_N` and `CLK`.

Reset:
- While `RST_N=0`: `CNT=0`, `CLK_Q=1`, `Q=0`, and `RCO=0` (for `WIDTH≥1`, since `Q=0` is not all ones).
- Because `CLK_Q` resets to 1, a `CLK` that is already high when reset is released does not produce a count. `CLK` must go low and then high again.

Boundary conditions:
- `CLR_N` low mid-count:
  - `SYNC_CLR=0`: `Q` is 0 in the same cycle.
  - `SYNC_CLR=1`: `Q` is 0 only after the next `RISE`.
- `CLR_N` and `LOAD_N` both low: clear wins.
- `CLR_N` released in the same `CLK_DRV` cycle as `RISE`, with `SYNC_CLR=0`: the edge acts normally (load or count from 0).
- `LOAD_N` low and enables high: load wins.
- `D` is sampled on the `RISE` edge only; `D` changing between edges has no effect.
- `CLK` pulse shorter than one `CLK_DRV` period: may be missed. This is outside the operating range and is not a bug.
- `ENT` toggling with `Q` at all ones: `RCO` follows `ENT` combinationally.

## Timing
- Count latency: `Q` updates at the first `CLK_DRV` edge where `CLK=1` and the previous sample was 0. The new value is visible immediately after that edge. There is no further pipeline delay.
- `RCO` latency is zero relative to `Q` and `ENT`.
- Async clear (`SYNC_CLR=0`): `Q` and `RCO` go to 0 combinationally. `CNT` becomes 0 at the next `CLK_DRV` edge.
- Minimum `CLK` high and low times: one `CLK_DRV` period each.
- There is exactly one action per `CLK` rising edge, regardless of how long `CLK` stays high.

## Test plan
- Reset release with `CLK` held high:
  - Stimulus: `RST_N` 0→1 with `CLK=1` and `ENP=ENT=1`.
  - Required response: `Q` stays 0. After `CLK` goes 0→1, `Q=1`.
- Full count and wrap (`WIDTH=4`, `ENP=ENT=1`):
  - Stimulus: 16 `CLK` rising edges.
  - Required response: `Q` runs 1..15, then 0. `RCO=1` only while `Q=15`. `RCO` drops to 0 when `ENT` is forced 0 at `Q=15`.
- Load priority:
  - Stimulus: `Q=5`, `D=4'hA`, `LOAD_N=0`, `ENP=ENT=1`, one `CLK` edge.
  - Required response: `Q=10`.
  - Stimulus: `LOAD_N=0` with no `CLK` edge for 10 `CLK_DRV` cycles.
  - Required response: `Q` stays 10.
- Enable hold:
  - Stimulus: `Q=3`, `ENP=0`, `ENT=1`, 3 `CLK` edges.
  - Required response: `Q=3` and `RCO=0`.
  - Stimulus: `ENP=1`, `ENT=0`, 3 `CLK` edges.
  - Required response: `Q=3`.
- Async clear (`SYNC_CLR=0`):
  - Stimulus: `Q=9`, pulse `CLR_N` low for 1 `CLK_DRV` cycle with no `CLK` edge.
  - Required response: `Q=0` during the pulse and `Q=0` after it.
  - Stimulus: `CLR_N=0` together with `LOAD_N=0`, `D=7`, and a `CLK` edge.
  - Required response: `Q=0`.
- Sync clear (`SYNC_CLR=1`):
  - Stimulus: `Q=9`, `CLR_N=0`, no `CLK` edge.
  - Required response: `Q=9`.
  - Stimulus: one `CLK` edge.
  - Required response: `Q=0`.
  - Stimulus: the same edge applied with `LOAD_N=0`, `D=7`.
  - Required response: `Q=0`.
